// File: rtl/mips_main.sv
// Single-cycle 32-bit MIPS subset core: fetch from an external byte image, register file,
// ALU and internal data memory. Optional beq/bne/j support is enabled by MIPS_BRANCH_EN.
module mips_main #(
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned DMEM_BYTES = 256
) (
    output logic [31:0] next_instruction,
    output logic [31:0] alu_result,
    input  logic [7:0]  instruction_mem [IMEM_BYTES],
    input  logic        clk,
    input  logic        reset
);

    localparam int unsigned ImemAw = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam int unsigned DmemAw = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MIPS_BRANCH_EN
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
`endif

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] regs_q [32];
    logic [7:0]  dmem_q [DMEM_BYTES];

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm;
    logic [31:0] rs_val, rt_val, ea, mem_rdata, result;
    logic        reg_we, mem_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    // Data memory wraps per byte, so each byte lane is reduced modulo the memory size.
    function automatic logic [DmemAw-1:0] dmem_idx(input logic [31:0] addr, input int unsigned k);
        return DmemAw'(((addr % DMEM_BYTES) + k) % DMEM_BYTES);
    endfunction

    // Bytes beyond the program image read as zero so the core falls into NOPs.
    always_comb begin
        instr = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            logic [31:0] idx;
            idx = pc_q + k;
            if (idx < IMEM_BYTES) begin
                instr[8*k +: 8] = instruction_mem[ImemAw'(idx)];
            end
        end
    end

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};
    assign zext_imm = {16'h0000, instr[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    assign ea       = rs_val + sext_imm;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        mem_rdata = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            mem_rdata[8*k +: 8] = dmem_q[dmem_idx(ea, k)];
        end
    end

    always_comb begin
        result    = '0;
        reg_we    = 1'b0;
        reg_waddr = rd;
        mem_we    = 1'b0;
        pc_d      = pc_plus4;
        case (opcode)
            OpRtype: begin
                reg_we = 1'b1;
                case (funct)
                    FnAdd:   result = rs_val + rt_val;
                    FnSub:   result = rs_val - rt_val;
                    FnAnd:   result = rs_val & rt_val;
                    FnOr:    result = rs_val | rt_val;
                    FnSlt:   result = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FnSll:   result = rt_val << shamt;
                    default: reg_we = 1'b0;
                endcase
            end
            OpAddi: begin
                result    = rs_val + sext_imm;
                reg_we    = 1'b1;
                reg_waddr = rt;
            end
            OpAndi: begin
                result    = rs_val & zext_imm;
                reg_we    = 1'b1;
                reg_waddr = rt;
            end
            OpOri: begin
                result    = rs_val | zext_imm;
                reg_we    = 1'b1;
                reg_waddr = rt;
            end
            OpLw: begin
                result    = ea;
                reg_we    = 1'b1;
                reg_waddr = rt;
            end
            OpSw: begin
                result = ea;
                mem_we = 1'b1;
            end
`ifdef MIPS_BRANCH_EN
            OpBeq: begin
                result = rs_val - rt_val;
                if (rs_val == rt_val) pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
            end
            OpBne: begin
                result = rs_val - rt_val;
                if (rs_val != rt_val) pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
            end
            OpJ: pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
`endif
            default: ;
        endcase
    end

    assign reg_wdata = (opcode == OpLw) ? mem_rdata : result;

    assign next_instruction = reset ? 32'd0 : instr;
    assign alu_result       = reset ? 32'd0 : result;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            for (int i = 0; i < int'(DMEM_BYTES); i++) dmem_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (reg_we && (reg_waddr != 5'd0)) regs_q[reg_waddr] <= reg_wdata;
            if (mem_we) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    dmem_q[dmem_idx(ea, k)] <= rt_val[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_main.sv
// Self-checking bench for mips_main: directed programs plus a random program, each step
// compared against an instruction-level ISA model kept in the bench.
module tb_mips_main;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem [256];
    logic [31:0] next_instruction, alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [7:0]  m_dmem [256];

    mips_main #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
        .next_instruction(next_instruction),
        .alu_result      (alu_result),
        .instruction_mem (imem),
        .clk             (clk),
        .reset           (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    task automatic put_word(input int unsigned widx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) imem[4*widx + k] = w[8*k +: 8];
    endtask

    function automatic logic [31:0] m_fetch(input logic [31:0] pc);
        logic [31:0] w, a;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            if (a < 256) w[8*k +: 8] = imem[a[7:0]];
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr);
        logic [31:0] w, a;
        for (int k = 0; k < 4; k++) begin
            a = addr + 32'(k);
            w[8*k +: 8] = m_dmem[a[7:0]];
        end
        return w;
    endfunction

    // Reset held across one edge; outputs must read zero while reset is high.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_instr_pre", next_instruction, 32'd0);
        check("rst_alu_pre", alu_result, 32'd0);
        @(posedge clk);
        #1;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 256; i++) m_dmem[i] = '0;
        check("rst_instr_post", next_instruction, 32'd0);
        check("rst_alu_post", alu_result, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    // Execute one instruction on the model and compare outputs before the edge.
    task automatic step();
        logic [31:0] ins, s, t, simm, res, nxt, ea, wd, tmp;
        logic [4:0]  wr;
        logic        we, st;
        ins  = m_fetch(m_pc);
        s    = m_regs[ins[25:21]];
        t    = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        ea   = s + simm;
        res  = '0;
        we   = 1'b0;
        st   = 1'b0;
        wr   = ins[15:11];
        wd   = '0;
        nxt  = m_pc + 32'd4;
        case (ins[31:26])
            6'h00: begin
                we = 1'b1;
                case (ins[5:0])
                    6'h20:   res = s + t;
                    6'h22:   res = s - t;
                    6'h24:   res = s & t;
                    6'h25:   res = s | t;
                    6'h2A:   res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
                    6'h00:   res = t << ins[10:6];
                    default: we = 1'b0;
                endcase
                wd = res;
            end
            6'h08: begin res = s + simm; we = 1'b1; wr = ins[20:16]; wd = res; end
            6'h0C: begin res = s & {16'h0, ins[15:0]}; we = 1'b1; wr = ins[20:16]; wd = res; end
            6'h0D: begin res = s | {16'h0, ins[15:0]}; we = 1'b1; wr = ins[20:16]; wd = res; end
            6'h23: begin res = ea; we = 1'b1; wr = ins[20:16]; wd = m_load(ea); end
            6'h2B: begin res = ea; st = 1'b1; end
`ifdef MIPS_BRANCH_EN
            6'h04: begin res = s - t; if (s == t) nxt = m_pc + 32'd4 + (simm << 2); end
            6'h05: begin res = s - t; if (s != t) nxt = m_pc + 32'd4 + (simm << 2); end
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
`endif
            default: ;
        endcase
        check($sformatf("instr@pc%0h", m_pc), next_instruction, ins);
        check($sformatf("alu@pc%0h", m_pc), alu_result, res);
        @(posedge clk);
        #1;
        if (we && wr != 5'd0) m_regs[wr] = wd;
        if (st) begin
            for (int k = 0; k < 4; k++) begin
                tmp = ea + 32'(k);
                m_dmem[tmp[7:0]] = t[8*k +: 8];
            end
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn [6];
        logic [5:0]  bad_op [4];
        int unsigned sel;
        fn     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        bad_op = '{6'h01, 6'h03, 6'h0F, 6'h3F};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0, 1, 2: begin
                automatic logic [5:0] f = fn[$urandom_range(0, 5)];
                if (f == 6'h00) return {6'h00, 5'd0, rt, rd, 5'($urandom), f};
                return {6'h00, rs, rt, rd, 5'd0, f};
            end
            3, 4:    return {6'h08, rs, rt, imm};
            5:       return {6'h0C, rs, rt, imm};
            6:       return {6'h0D, rs, rt, imm};
            7, 8:    return {6'h23, rs, rt, imm};
            9, 10:   return {6'h2B, rs, rt, imm};
            default: begin
                if ($urandom_range(0, 1) == 0) return {6'h00, rs, rt, rd, 5'd0, 6'h21};
                return {bad_op[$urandom_range(0, 3)], rs, rt, imm};
            end
        endcase
    endfunction

    initial begin
        clear_imem();
        // Directed program: arithmetic, memory round trip, $0 discard and wrap-around.
        put_word(0, 32'h200A000A);   // addi $10,$0,10
        put_word(1, 32'h016A5820);   // add  $11,$11,$10
        put_word(2, 32'h200A000D);   // addi $10,$0,13
        put_word(3, 32'h014B6022);   // sub  $12,$10,$11
        put_word(4, 32'hAD4C0000);   // sw   $12,0($10)
        put_word(5, 32'h8D4D0000);   // lw   $13,0($10)
        put_word(6, 32'h01A00820);   // add  $1,$13,$0
        put_word(7, 32'h20000005);   // addi $0,$0,5
        put_word(8, 32'h00000820);   // add  $1,$0,$0
        put_word(9, 32'h2001FFFF);   // addi $1,$0,-1
        put_word(10, 32'h20210001);  // addi $1,$1,1
        put_word(11, 32'h00200020);  // add  $0,$1,$0 (reads $1)
        #1;
        do_reset();

        check("t1_instr", next_instruction, 32'h200A000A);
        check("t1_alu", alu_result, 32'd10);
        for (int i = 0; i < 3; i++) step();
        check("t2_sub_alu", alu_result, 32'd3);
        step();
        check("t3_sw_alu", alu_result, 32'd13);
        step();
        check("t3_lw_alu", alu_result, 32'd13);
        step();
        check("t3_lw_readback", alu_result, 32'd3);
        for (int i = 0; i < 5; i++) step();
        check("t4_wrap_readback", alu_result, 32'd0);
        for (int i = 0; i < 60; i++) step();   // runs past the end of the image
        check("t5_past_end_instr", next_instruction, 32'd0);

        // Mid-program reset then identical rerun.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        do_reset();
        check("t6_rerun_instr", next_instruction, 32'h200A000A);
        for (int i = 0; i < 14; i++) step();

        // Random program with register readbacks at the end.
        clear_imem();
        for (int i = 0; i < 57; i++) put_word(i, rand_instr());
        for (int r = 1; r < 8; r++) put_word(56 + r, {6'h00, 5'(r), 5'd0, 5'd0, 5'd0, 6'h20});
        do_reset();
        for (int i = 0; i < 67; i++) step();

        // Branch/jump opcodes: taken loop when enabled, NOPs otherwise.
        clear_imem();
        put_word(0, 32'h20010007);   // addi $1,$0,7
        put_word(1, 32'h1000FFFF);   // beq  $0,$0,-1
        put_word(2, 32'h08000010);   // j    0x40
        put_word(3, 32'h14200001);   // bne  $1,$0,+1
        do_reset();
        for (int i = 0; i < 4; i++) step();
`ifdef MIPS_BRANCH_EN
        check("beq_loop_instr", next_instruction, 32'h1000FFFF);
`else
        check("no_branch_nop_pc", next_instruction, 32'h00000000);
`endif
        for (int i = 0; i < 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
